// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, WIDTH+1 cycles per result.
// Optional subtract mode (sub port, a - b) is compiled in with `define SERIAL_ADDER_SUB_EN.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             c;
    logic [CW-1:0]    cnt;

    logic             s_bit;
    logic             c_next;
    logic             accept;
    logic [WIDTH-1:0] b_load;
    logic             c_load;

    // NOTE: every signal driven here is assigned on every path, so no latch is inferred.
    always_comb begin
        s_bit  = a_sh[0] ^ b_sh[0] ^ c;
        c_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & c) | (b_sh[0] & c);
        accept = start && (state == IDLE || state == DONE);
`ifdef SERIAL_ADDER_SUB_EN
        // Two's-complement subtract: invert B and force the carry-in to 1.
        b_load = sub ? ~b : b;
        c_load = sub | cin;
`else
        b_load = b;
        c_load = cin;
`endif
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            c        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            // NOTE: a_sh/b_sh/res are left out of reset; they are always loaded before use.
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        a_sh  <= a;
                        b_sh  <= b_load;
                        c     <= c_load;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    res  <= {s_bit, res[WIDTH-1:1]};
                    c    <= c_next;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // On the MSB step c still holds the carry into the MSB.
                        sum      <= {s_bit, res[WIDTH-1:1]};
                        cout     <= c_next;
                        overflow <= c ^ c_next;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: directed cases on an 8-bit instance,
// randomized sweep on a 16-bit instance, both checked against an arithmetic model.
module tb_serial_adder;

    typedef struct {
        longint sum;
        logic   cout;
        logic   ovf;
        longint due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    longint cyc = 0;
    int total = 0;
    int bad = 0;

    logic        start8 = 1'b0, cin8 = 1'b0, sub8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, cout8, ovf8;
    logic [7:0]  sum8;

    logic        start16 = 1'b0, cin16 = 1'b0, sub16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum16;

    exp_t q8[$];
    exp_t q16[$];
    exp_t hold8 = '{0, 1'b0, 1'b0, 0};
    exp_t hold16 = '{0, 1'b0, 1'b0, 0};
    exp_t m8, m16;
    logic exp_busy8, exp_busy16;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub8),
`endif
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .overflow(ovf8)
    );

    serial_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub16),
`endif
        .busy(busy16), .done(done16), .sum(sum16), .cout(cout16), .overflow(ovf16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Reference: plain integer arithmetic on the operands' unsigned and signed values.
    function automatic exp_t model(input int w, input longint av, input longint bv,
                                   input logic cv, input logic sv, input longint due);
        exp_t e;
        longint m, lim, sa, sb, r, full;
        m   = longint'(1) <<< w;
        lim = m / 2;
        sa  = (av >= lim) ? av - m : av;
        sb  = (bv >= lim) ? bv - m : bv;
        if (sv) begin
            e.sum  = (av - bv + m) % m;
            e.cout = (av >= bv);
            r      = sa - sb;
        end else begin
            full   = av + bv + longint'(cv);
            e.sum  = full % m;
            e.cout = (full >= m);
            r      = sa + sb + longint'(cv);
        end
        e.ovf = (r >= lim) || (r < -lim);
        e.due = due;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic cv, input logic sv);
        start8 = 1'b1; a8 = av; b8 = bv; cin8 = cv; sub8 = sv;
        q8.push_back(model(8, longint'(av), longint'(bv), cv, sv, cyc + 9));
        tick();
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'b0;
    endtask

    task automatic op16(input logic [15:0] av, input logic [15:0] bv, input logic cv, input logic sv);
        start16 = 1'b1; a16 = av; b16 = bv; cin16 = cv; sub16 = sv;
        q16.push_back(model(16, longint'(av), longint'(bv), cv, sv, cyc + 17));
        tick();
        start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom); sub16 = 1'b0;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy8"}, longint'(busy8), 0);
        check({tag, "_done8"}, longint'(done8), 0);
        check({tag, "_sum8"}, longint'(sum8), 0);
        check({tag, "_cout8"}, longint'(cout8), 0);
        check({tag, "_ovf8"}, longint'(ovf8), 0);
        check({tag, "_busy16"}, longint'(busy16), 0);
        check({tag, "_sum16"}, longint'(sum16), 0);
    endtask

    // Monitor for the 8-bit instance: busy window, done timing, result, and hold behaviour.
    always @(negedge clk) begin
        if (!rst) begin
            exp_busy8 = (q8.size() > 0) && (cyc >= q8[0].due - 8) && (cyc < q8[0].due);
            check("busy8", longint'(busy8), longint'(exp_busy8));
            if (done8) begin
                if (q8.size() == 0) begin
                    check("unexpected_done8", longint'(done8), 0);
                end else begin
                    m8 = q8.pop_front();
                    check("done_cycle8", cyc, m8.due);
                    check("sum8", longint'(sum8), m8.sum);
                    check("cout8", longint'(cout8), longint'(m8.cout));
                    check("ovf8", longint'(ovf8), longint'(m8.ovf));
                    hold8 = m8;
                end
            end else begin
                check("hold_sum8", longint'(sum8), hold8.sum);
                check("hold_cout8", longint'(cout8), longint'(hold8.cout));
                check("hold_ovf8", longint'(ovf8), longint'(hold8.ovf));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            exp_busy16 = (q16.size() > 0) && (cyc >= q16[0].due - 16) && (cyc < q16[0].due);
            check("busy16", longint'(busy16), longint'(exp_busy16));
            if (done16) begin
                if (q16.size() == 0) begin
                    check("unexpected_done16", longint'(done16), 0);
                end else begin
                    m16 = q16.pop_front();
                    check("done_cycle16", cyc, m16.due);
                    check("sum16", longint'(sum16), m16.sum);
                    check("cout16", longint'(cout16), longint'(m16.cout));
                    check("ovf16", longint'(ovf16), longint'(m16.ovf));
                    hold16 = m16;
                end
            end else begin
                check("hold_sum16", longint'(sum16), hold16.sum);
                check("hold_cout16", longint'(cout16), longint'(hold16.cout));
                check("hold_ovf16", longint'(ovf16), longint'(hold16.ovf));
            end
        end
    end

    initial begin
        int junk_at;
        logic sv;

        rst = 1'b1;
        tick();
        tick();
        check_zero_outputs("reset");
        rst = 1'b0;
        tick();

        // Directed 8-bit cases, chained back-to-back through the DONE cycle.
        op8(8'h3C, 8'h5A, 1'b0, 1'b0);
        repeat (8) tick();
        op8(8'h01, 8'h01, 1'b0, 1'b0);
        check("b2b_busy8", longint'(busy8), 1);
        repeat (8) tick();
        op8(8'hFF, 8'h01, 1'b0, 1'b0);
        repeat (8) tick();
        op8(8'h00, 8'h00, 1'b1, 1'b0);
        repeat (9) tick();

        // Reset in the middle of an operation: it must vanish without a done pulse.
        op8(8'h12, 8'h34, 1'b0, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        q8.delete();
        hold8 = '{0, 1'b0, 1'b0, 0};
        hold16 = '{0, 1'b0, 1'b0, 0};
        tick();
        check_zero_outputs("midop_reset");
        rst = 1'b0;
        repeat (12) tick();
        op8(8'h0F, 8'h01, 1'b0, 1'b0);
        repeat (9) tick();

`ifdef SERIAL_ADDER_SUB_EN
        op8(8'h10, 8'h20, 1'b0, 1'b1);
        repeat (8) tick();
        op8(8'h80, 8'h01, 1'b1, 1'b1);
        repeat (9) tick();
`endif

        // Random 16-bit sweep with stray starts during RUN and random gaps or back-to-back.
        for (int n = 0; n < 1000; n++) begin
`ifdef SERIAL_ADDER_SUB_EN
            sv = 1'($urandom);
`else
            sv = 1'b0;
`endif
            op16(16'($urandom), 16'($urandom), 1'($urandom), sv);
            junk_at = int'($urandom_range(0, 40));
            for (int i = 0; i < 16; i++) begin
                if (i == junk_at) begin
                    start16 = 1'b1;
                    a16 = 16'($urandom);
                    b16 = 16'($urandom);
                end else begin
                    start16 = 1'b0;
                end
                tick();
            end
            start16 = 1'b0;
            if ($urandom_range(0, 1) == 0) begin
                repeat ($urandom_range(1, 3)) tick();
            end
        end

        repeat (30) tick();
        check("drained8", longint'(q8.size()), 0);
        check("drained16", longint'(q16.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised bit-serial adder: adds two WIDTH-bit operands one bit per clock using a single full-adder cell and a carry flip-flop. It trades latency for area. It sits beside the gate-level adder cells as their multi-bit successor, with a start/done handshake, carry-in, carry-out and signed-overflow flags. It is intended for datapaths where a WIDTH-cycle latency is acceptable.

## Interface
- WIDTH, default 8: operand and result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- a  input  WIDTH  operand A, captured on the accepting edge.
- b  input  WIDTH  operand B, captured on the accepting edge.
- cin  input  1  carry-in, captured on the accepting edge.
- sub  input  1  subtract select; present only with SERIAL_ADDER_SUB_EN.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when the result is valid.
- sum  output  WIDTH  result; holds its value until the next completion.
- cout  output  1  carry out of the MSB.
- overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE. Bit counter is ceil(log2(WIDTH)) bits wide.
- IDLE, start=1: capture a and b into shift registers, load carry with cin, clear the counter, go to RUN.
- IDLE, start=0: stay in IDLE.
- RUN, each edge:
  - Bit s = a_sh[0] ^ b_sh[0] ^ c.
  - Carry c <= majority(a_sh[0], b_sh[0], c).
  - Shift both operands right.
  - Shift s into the MSB of the internal result register.
  - Increment the counter.
- Before the MSB update, record the carry into the MSB.
- RUN, counter = WIDTH-1: finish the final bit, then load sum, cout and overflow from internal state, go to DONE.
- DONE, lasting one cycle: done=1.
  - start=1: accept a new operation, same as in IDLE, and go to RUN.
  - start=0: go to IDLE.
- start is ignored in RUN. No queuing.
- The operands a, b and cin need only be valid on the accepting edge.
- sum, cout and overflow change only on the completion edge. During RUN they keep the previous result.
- Arithmetic is modulo 2^WIDTH.
- rst=1 at any edge, including mid-operation:
  - state goes to IDLE and the counter clears;
  - busy=0, done=0, sum=0, cout=0, overflow=0;
  - the in-flight operation is discarded and never signals done.

## Timing
- If start is accepted at edge E0:
  - busy is high for cycles 1..WIDTH;
  - done and the new result are visible in cycle WIDTH+1.
- Latency: WIDTH+1 cycles from start to done.
- Throughput: one result per WIDTH+1 cycles, using the back-to-back start from DONE.
- Reset values of all outputs: 0.
- busy and done are never high together.

## Configuration
- SERIAL_ADDER_SUB_EN defined:
  - the sub port exists and is captured with the operands;
  - sub=1 computes a - b: B is inverted at capture, carry is loaded with 1, and cin is ignored;
  - cout=1 means no borrow;
  - overflow uses the same MSB carry rule.
- SERIAL_ADDER_SUB_EN undefined:
  - no sub port and no inverter logic;
  - the block is an adder only.

## Test plan
- WIDTH=8, a=0x3C, b=0x5A, cin=0 -> done in cycle 9; sum=0x96, cout=0, overflow=1.
- WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, overflow=0. Then a=0x00, b=0x00, cin=1 -> sum=0x01, cout=0.
- Back-to-back: assert start during the DONE cycle with a=0x01, b=0x01 -> busy high the next cycle; second done 9 cycles later with sum=0x02. Previous sum 0x96 holds until then.
- Reset mid-operation: start, then rst=1 in cycle 4 -> all outputs 0, no done pulse, state IDLE. A following start completes normally.
- With SERIAL_ADDER_SUB_EN, WIDTH=8: a=0x10, b=0x20, sub=1 -> sum=0xF0, cout=0, overflow=0. Then a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, overflow=1.
- WIDTH=16 random sweep of 1000 operations against a reference model -> sum, cout and overflow match; done exactly 17 cycles after each start.
